wb_write_queue: RTL

Write-back queue that is the writer for the processor's 8×16-bit register file. It accepts results from the memory stage and the ALU stage, serialises them onto the register file's single write port one per cycle, and forwards pending, not-yet-committed values to the decode-stage read ports. It sits between the MEM/WB pipeline registers and the register file.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fwd_match.sv | 33 +++
 rtl/wb_write_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back queue: register-file geometry and the queued entry.
package wb_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Priority comparator over the queue ring: scans oldest to youngest from the head
// so the youngest matching valid entry ends up on the outputs.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && entries[idx].addr == lookup_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue serialising MEM/ALU results onto the register-file write port.
// Optional forwarding to decode read ports is built only when WB_FWD_EN is defined.
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_valid,
    input  logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_data,
    input  logic                          alu_valid,
    input  logic [ADDR_W-1:0]             alu_addr,
    input  logic [DATA_W-1:0]             alu_data,
    output logic                          wq_ready,
    output logic                          reg_write,
    output logic [ADDR_W-1:0]             write_addr,
    output logic [DATA_W-1:0]             write_data,
    input  logic [ADDR_W-1:0]             lookup_addr1,
    input  logic [ADDR_W-1:0]             lookup_addr2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [DATA_W-1:0]             fwd_data1,
    output logic [DATA_W-1:0]             fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;
    logic               overflow_q, overflow_d;

    logic               pop, mem_acc, alu_acc;
    logic [CNT_W:0]     free_slots;

    always_comb begin
        pop        = (count_q != '0);
        // The slot freed by this cycle's pop is already reusable by this cycle's enqueues.
        free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};
        mem_acc    = mem_valid && (free_slots != '0);
        alu_acc    = alu_valid && (free_slots > {{CNT_W{1'b0}}, mem_acc});

        mem_d  = mem_q;
        tail_d = tail_q;
        if (mem_acc) begin
            mem_d[tail_d] = '{addr: mem_addr, data: mem_data};
            tail_d        = tail_d + 1'b1;
        end
        if (alu_acc) begin
            mem_d[tail_d] = '{addr: alu_addr, data: alu_data};
            tail_d        = tail_d + 1'b1;
        end

        head_d       = head_q + PTR_W'(pop);
        count_d      = count_q - CNT_W'(pop) + CNT_W'(mem_acc) + CNT_W'(alu_acc);
        reg_write_d  = pop;
        write_addr_d = pop ? mem_q[head_q].addr : write_addr_q;
        write_data_d = pop ? mem_q[head_q].data : write_data_q;
        overflow_d   = overflow_q | (mem_valid & ~mem_acc) | (alu_valid & ~alu_acc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            overflow_q   <= overflow_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign wq_ready   = ((CNT_W+1)'(DEPTH) - {1'b0, count_q}) >= (CNT_W+1)'(2);

`ifdef WB_FWD_EN
    logic [DEPTH-1:0]   valid_mask;
    logic               q_hit1, q_hit2, out_hit1, out_hit2;
    logic [DATA_W-1:0]  q_data1, q_data2;

    for (genvar j = 0; j < DEPTH; j++) begin : g_valid
        logic [PTR_W-1:0] rel;
        assign rel           = PTR_W'(j) - head_q;
        assign valid_mask[j] = ({1'b0, rel} < count_q);
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries(mem_q), .valid(valid_mask), .head(head_q),
        .lookup_addr(lookup_addr1), .hit(q_hit1), .data(q_data1)
    );
    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries(mem_q), .valid(valid_mask), .head(head_q),
        .lookup_addr(lookup_addr2), .hit(q_hit2), .data(q_data2)
    );

    // The output register is older than anything still in the ring.
    assign out_hit1  = reg_write_q && (write_addr_q == lookup_addr1);
    assign out_hit2  = reg_write_q && (write_addr_q == lookup_addr2);
    assign fwd_hit1  = q_hit1 | out_hit1;
    assign fwd_hit2  = q_hit2 | out_hit2;
    assign fwd_data1 = q_hit1 ? q_data1 : (out_hit1 ? write_data_q : '0);
    assign fwd_data2 = q_hit2 ? q_data2 : (out_hit2 ? write_data_q : '0);
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_addr1, lookup_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule
